// File: rtl/udpcnt_pkg.sv
// ============================================================================
// Module   : udpcnt_pkg
// Purpose  : Shared types and constants for the UDP sequence-counter link
//            test (initiator and responder ends).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package udpcnt_pkg;

  // Transmit sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    DATA = 3'd2,
    TAIL = 3'd3,
    GAP  = 3'd4
  } tx_state_t;

  // UDP header length in bytes, added to the payload for the length field
  localparam int UDPHDRLEN = 8;

  // Default port pair; the responder uses the same values mirrored
  localparam logic [15:0] DEFAULT_LOCALPORT  = 16'hd003;
  localparam logic [15:0] DEFAULT_REMOTEPORT = 16'hd002;

  // Payload carries exactly one counter value
  function automatic int PAYLOADBYTES(input int cntwidth);
    return cntwidth / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/udpcnt_rxchk.sv
// ============================================================================
// Module   : udpcnt_rxchk
// Purpose  : Reply receiver for the sequence-counter initiator. Filters
//            headers on the port pair, collects the payload, then checks
//            error flag, length and reply-counter continuity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module udpcnt_rxchk
  import udpcnt_pkg::*;
#(
  parameter logic [15:0] LOCALPORT  = DEFAULT_LOCALPORT,
  parameter logic [15:0] REMOTEPORT = DEFAULT_REMOTEPORT,
  parameter int          CNTWIDTH   = 64,
  parameter int          ERRWIDTH   = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                newhead,
  input  logic [15:0]         dstport,
  input  logic [15:0]         srcport,
  input  logic [7:0]          data,
  input  logic                dven,
  input  logic                error,
  output logic [CNTWIDTH-1:0] rxcnt,
  output logic [ERRWIDTH-1:0] seqerr,
  output logic [ERRWIDTH-1:0] lenerr,
  output logic [ERRWIDTH-1:0] rxerr,
  output logic [7:0]          remote_err,
  output logic                reply_ok
);

  localparam int          NBYTES   = PAYLOADBYTES(CNTWIDTH);
  localparam int          SEQW     = CNTWIDTH - 8;
  localparam logic [15:0] NBYTES16 = 16'(NBYTES);

  logic                active;
  logic                dven_d;
  logic                err_acc;
  logic                eop;
  logic [15:0]         nbytes;
  logic [CNTWIDTH-1:0] shift;
  logic [SEQW-1:0]     expected;

  logic                hdr_match;
  logic                fall;
  logic [SEQW-1:0]     rx_seq;

  assign hdr_match = newhead && (dstport == LOCALPORT) && (srcport == REMOTEPORT);
  // Packet end is the first cycle with dven low after a byte of an accepted packet
  assign fall      = active && dven_d && !dven;
  // Byte 0 is the responder's error count, the remaining bytes its counter
  assign rx_seq    = shift[SEQW-1:0];
  // A well-formed reply is being retired this cycle
  assign reply_ok  = eop && !err_acc && (nbytes == NBYTES16);

  // Header filter and payload collection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active  <= 1'b0;
      dven_d  <= 1'b0;
      err_acc <= 1'b0;
      eop     <= 1'b0;
      nbytes  <= '0;
      shift   <= '0;
    end else begin
      dven_d <= dven;
      eop    <= fall;
      if (hdr_match) begin
        active  <= 1'b1;
        nbytes  <= '0;
        err_acc <= 1'b0;
      end else if (newhead || fall) begin
        active <= 1'b0;
      end else if (active && dven) begin
        shift   <= {shift[CNTWIDTH-9:0], data};
        err_acc <= err_acc | error;
        if (nbytes != '1) nbytes <= nbytes + 16'd1;
      end
    end
  end

  // End-of-packet checks and statistics, one cycle after the dven fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxcnt      <= '0;
      seqerr     <= '0;
      lenerr     <= '0;
      rxerr      <= '0;
      remote_err <= '0;
      expected   <= '0;
    end else if (eop) begin
      if (err_acc) begin
        if (rxerr != '1) rxerr <= rxerr + ERRWIDTH'(1);
      end else if (nbytes != NBYTES16) begin
        if (lenerr != '1) lenerr <= lenerr + ERRWIDTH'(1);
      end else begin
        rxcnt      <= rxcnt + CNTWIDTH'(1);
        remote_err <= shift[CNTWIDTH-1 -: 8];
        if (rx_seq != expected) begin
          if (seqerr != '1) seqerr <= seqerr + ERRWIDTH'(1);
          // Resynchronise on the responder's counter
          expected <= rx_seq + SEQW'(1);
        end else begin
          expected <= expected + SEQW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/udpcnt_gen.sv
// ============================================================================
// Module   : udpcnt_gen
// Purpose  : Initiator end of the UDP sequence-counter link test. Sends
//            periodic big-endian sequence packets, checks the replies and
//            counts reply timeouts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module udpcnt_gen
  import udpcnt_pkg::*;
#(
  parameter logic [15:0] LOCALPORT  = DEFAULT_LOCALPORT,
  parameter logic [15:0] REMOTEPORT = DEFAULT_REMOTEPORT,
  parameter int          CNTWIDTH   = 64,
  parameter int          ERRWIDTH   = 32,
  parameter logic [31:0] TIMEOUT    = 32'd125000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [31:0]         period,
  output logic                udp_request,
  input  logic                udp_ack,
  output logic [7:0]          udp_tx_data,
  output logic                udp_tx_dven,
  output logic                udp_tx_error,
  output logic [15:0]         udp_tx_srcport,
  output logic [15:0]         udp_tx_dstport,
  output logic [15:0]         udp_tx_length,
  output logic [15:0]         udp_tx_checksum,
  input  logic                udp_rx_newhead,
  input  logic [15:0]         udp_rx_dstport,
  input  logic [15:0]         udp_rx_srcport,
  input  logic [7:0]          udp_rx_data,
  input  logic                udp_rx_dven,
  input  logic                udp_rx_error,
  output logic [CNTWIDTH-1:0] txcnt,
  output logic [CNTWIDTH-1:0] rxcnt,
  output logic [ERRWIDTH-1:0] seqerr,
  output logic [ERRWIDTH-1:0] lenerr,
  output logic [ERRWIDTH-1:0] rxerr,
  output logic [ERRWIDTH-1:0] timeouts,
  output logic [7:0]          remote_err
);

  localparam int         NBYTES   = PAYLOADBYTES(CNTWIDTH);
  localparam logic [7:0] LASTBYTE = 8'(NBYTES - 1);

  tx_state_t           state;
  tx_state_t           state_nx;
  logic [7:0]          byte_idx;
  logic [31:0]         gap_cnt;
  logic [CNTWIDTH-1:0] seq;
  logic [CNTWIDTH-1:0] tx_shift;
  logic [31:0]         timer;
  logic                armed;
  logic                reply_ok;
  logic                gap_done;

  // gap_cnt starts at 1 so period=0 still yields a single GAP cycle
  assign gap_done = (gap_cnt >= period);

  assign udp_tx_error    = 1'b0;
  assign udp_tx_srcport  = LOCALPORT;
  assign udp_tx_dstport  = REMOTEPORT;
  assign udp_tx_length   = 16'(NBYTES + UDPHDRLEN);
  assign udp_tx_checksum = 16'h0000;

  // TX state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // TX next-state logic; enable is only sampled in IDLE so packets complete
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (enable) state_nx = REQ;
      REQ:     if (udp_ack) state_nx = DATA;
      DATA:    if (byte_idx == LASTBYTE) state_nx = TAIL;
      TAIL:    state_nx = GAP;
      GAP:     if (gap_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // TX outputs; data is forced to zero outside DATA
  always_comb begin
    udp_request = 1'b0;
    udp_tx_dven = 1'b0;
    udp_tx_data = 8'h00;
    case (state)
      REQ: udp_request = 1'b1;
      DATA: begin
        udp_tx_dven = 1'b1;
        udp_tx_data = tx_shift[CNTWIDTH-1 -: 8];
      end
      default: ;
    endcase
  end

  // TX datapath: byte shifter, byte and gap counters, sequence and txcnt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= '0;
      gap_cnt  <= '0;
      seq      <= '0;
      tx_shift <= '0;
      txcnt    <= '0;
    end else begin
      case (state)
        REQ: begin
          byte_idx <= '0;
          tx_shift <= seq;
        end
        DATA: begin
          byte_idx <= byte_idx + 8'd1;
          tx_shift <= {tx_shift[CNTWIDTH-9:0], 8'h00};
        end
        TAIL: begin
          txcnt   <= txcnt + CNTWIDTH'(1);
          seq     <= seq + CNTWIDTH'(1);
          gap_cnt <= 32'd1;
        end
        GAP: if (!gap_done) gap_cnt <= gap_cnt + 32'd1;
        default: ;
      endcase
    end
  end

  // Reply timer: armed at TAIL, cleared by a good reply (which beats expiry)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer    <= '0;
      armed    <= 1'b0;
      timeouts <= '0;
    end else if (state == TAIL) begin
      timer <= TIMEOUT;
      armed <= 1'b1;
    end else if (reply_ok) begin
      armed <= 1'b0;
    end else if (armed) begin
      timer <= timer - 32'd1;
      if (timer <= 32'd1) begin
        armed <= 1'b0;
        if (timeouts != '1) timeouts <= timeouts + ERRWIDTH'(1);
      end
    end
  end

  udpcnt_rxchk #(
    .LOCALPORT  (LOCALPORT),
    .REMOTEPORT (REMOTEPORT),
    .CNTWIDTH   (CNTWIDTH),
    .ERRWIDTH   (ERRWIDTH)
  ) u_rxchk (
    .clk        (clk),
    .reset      (reset),
    .newhead    (udp_rx_newhead),
    .dstport    (udp_rx_dstport),
    .srcport    (udp_rx_srcport),
    .data       (udp_rx_data),
    .dven       (udp_rx_dven),
    .error      (udp_rx_error),
    .rxcnt      (rxcnt),
    .seqerr     (seqerr),
    .lenerr     (lenerr),
    .rxerr      (rxerr),
    .remote_err (remote_err),
    .reply_ok   (reply_ok)
  );

endmodule

`default_nettype wire

// File: tb/tb_udpcnt_gen.sv
// ============================================================================
// Module   : tb_udpcnt_gen
// Purpose  : Self-checking bench for udpcnt_gen with a cycle-tracking
//            behavioural model of packets, replies and the reply timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udpcnt_gen;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] period;
  logic        udp_request, udp_ack;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_dven, udp_tx_error;
  logic [15:0] udp_tx_srcport, udp_tx_dstport, udp_tx_length, udp_tx_checksum;
  logic        udp_rx_newhead;
  logic [15:0] udp_rx_dstport, udp_rx_srcport;
  logic [7:0]  udp_rx_data;
  logic        udp_rx_dven, udp_rx_error;
  logic [63:0] txcnt, rxcnt;
  logic [31:0] seqerr, lenerr, rxerr, timeouts;
  logic [7:0]  remote_err;

  always #5 clk = ~clk;

  udpcnt_gen #(.TIMEOUT(32'd100)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .udp_request(udp_request), .udp_ack(udp_ack),
    .udp_tx_data(udp_tx_data), .udp_tx_dven(udp_tx_dven), .udp_tx_error(udp_tx_error),
    .udp_tx_srcport(udp_tx_srcport), .udp_tx_dstport(udp_tx_dstport),
    .udp_tx_length(udp_tx_length), .udp_tx_checksum(udp_tx_checksum),
    .udp_rx_newhead(udp_rx_newhead), .udp_rx_dstport(udp_rx_dstport),
    .udp_rx_srcport(udp_rx_srcport), .udp_rx_data(udp_rx_data),
    .udp_rx_dven(udp_rx_dven), .udp_rx_error(udp_rx_error),
    .txcnt(txcnt), .rxcnt(rxcnt), .seqerr(seqerr), .lenerr(lenerr),
    .rxerr(rxerr), .timeouts(timeouts), .remote_err(remote_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hffffffff) ? v : v + 32'd1;
  endfunction

  // ---------------- behavioural model state ----------------
  longint      ncyc = 0;
  logic [63:0] exp_txcnt, exp_rxcnt, model_seq;
  logic [31:0] exp_seqerr, exp_lenerr, exp_rxerr, exp_timeouts;
  logic [7:0]  exp_remote;
  logic [55:0] exp_ctr;
  bit          tm_armed;
  longint      tm_e, tx_vis, last_tail, last_gap;
  bit          pend_v, pend_err;
  longint      pend_c;
  int          pend_n;
  logic [63:0] pend_val;
  bit          m_active, m_err;
  int          m_n;
  logic [63:0] m_val;
  logic [63:0] t_val;
  int          t_n;
  logic [63:0] pkt_log[$];
  bit          prev_dven, prev_req, prev_en, prev_rxdv;

  // Model update and per-cycle comparison, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (reset) begin
        exp_txcnt = 0; exp_rxcnt = 0; model_seq = 0; exp_ctr = 0;
        exp_seqerr = 0; exp_lenerr = 0; exp_rxerr = 0; exp_timeouts = 0;
        exp_remote = 0; tm_armed = 0; tx_vis = -1; last_tail = -1;
        pend_v = 0; m_active = 0; t_val = 0; t_n = 0;
        prev_dven = 0; prev_req = 0; prev_en = 0; prev_rxdv = 0;
      end else begin
        // results that become visible this cycle
        if (tx_vis == ncyc) exp_txcnt = exp_txcnt + 64'd1;
        if (pend_v && pend_c == ncyc) begin
          pend_v = 0;
          if (pend_err) exp_rxerr = sat32(exp_rxerr);
          else if (pend_n != 8) exp_lenerr = sat32(exp_lenerr);
          else begin
            exp_rxcnt  = exp_rxcnt + 64'd1;
            exp_remote = pend_val[63:56];
            if (pend_val[55:0] != exp_ctr) begin
              exp_seqerr = sat32(exp_seqerr);
              exp_ctr    = pend_val[55:0] + 56'd1;
            end else begin
              exp_ctr = exp_ctr + 56'd1;
            end
            // the reply was retired in the previous cycle; it beats an expiry there
            if (tm_armed && (ncyc - 1) <= tm_e) tm_armed = 0;
          end
        end
        // timeout fires TO cycles after the TAIL cycle, visible one cycle later
        if (tm_armed && ncyc == tm_e + 1) begin
          tm_armed     = 0;
          exp_timeouts = sat32(exp_timeouts);
        end

        check("txcnt", txcnt, exp_txcnt);
        check("rxcnt", rxcnt, exp_rxcnt);
        check("seqerr", 64'(seqerr), 64'(exp_seqerr));
        check("lenerr", 64'(lenerr), 64'(exp_lenerr));
        check("rxerr", 64'(rxerr), 64'(exp_rxerr));
        check("timeouts", 64'(timeouts), 64'(exp_timeouts));
        check("remote_err", 64'(remote_err), 64'(exp_remote));
        if (!udp_tx_dven) check("tx_data_idle", 64'(udp_tx_data), 64'd0);

        // transmit side: collect bytes, close packet on dven fall (TAIL)
        if (udp_tx_dven) begin
          t_val = {t_val[55:0], udp_tx_data};
          t_n++;
        end else if (prev_dven) begin
          check("tx_len", 64'(t_n), 64'd8);
          check("tx_seq", t_val, model_seq);
          pkt_log.push_back(t_val);
          model_seq = model_seq + 64'd1;
          t_val = 0; t_n = 0;
          tx_vis = ncyc + 1;
          tm_armed = 1; tm_e = ncyc + TO;
          last_tail = ncyc;
        end
        if (udp_request && !prev_req) begin
          check("req_needs_enable", 64'(prev_en), 64'd1);
          if (last_tail >= 0) begin
            // GAP of max(period,1) cycles, then one IDLE cycle
            last_gap = ncyc - last_tail;
            check("gap", 64'(last_gap), 64'((period == 0 ? 1 : period) + 2));
          end
        end
        if (!enable) last_tail = -1;

        // receive side: accept only the right port pair
        if (udp_rx_newhead && udp_rx_dstport == 16'hd003 && udp_rx_srcport == 16'hd002) begin
          m_active = 1; m_n = 0; m_err = 0; m_val = 0;
        end else if (m_active && udp_rx_dven) begin
          m_val = {m_val[55:0], udp_rx_data};
          m_n++;
          m_err = m_err | udp_rx_error;
        end else if (m_active && prev_rxdv) begin
          m_active = 0;
          pend_v = 1; pend_c = ncyc + 2;
          pend_err = m_err; pend_n = m_n; pend_val = m_val;
        end

        prev_dven = udp_tx_dven;
        prev_req  = udp_request;
        prev_en   = enable;
        prev_rxdv = udp_rx_dven;
      end
    end
  end

  // Core grant: ack two cycles after the request is first seen
  initial begin
    udp_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (udp_request && !reset) begin
        @(posedge clk); @(posedge clk); #1;
        udp_ack = 1'b1;
        @(posedge clk); #1;
        udp_ack = 1'b0;
      end
    end
  end

  task automatic send_reply(input logic [15:0] dst, input logic [15:0] src,
                            input int n, input logic [63:0] payload, input int err_at);
    @(posedge clk); #1;
    udp_rx_newhead = 1'b1; udp_rx_dstport = dst; udp_rx_srcport = src;
    @(posedge clk); #1;
    udp_rx_newhead = 1'b0;
    for (int i = 0; i < n; i++) begin
      udp_rx_dven  = 1'b1;
      udp_rx_data  = payload[63-8*i -: 8];
      udp_rx_error = (i == err_at);
      @(posedge clk); #1;
    end
    udp_rx_dven = 1'b0; udp_rx_data = 8'h00; udp_rx_error = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int i;
    int base;
    reset = 1'b1; enable = 1'b0; period = 32'd10;
    udp_rx_newhead = 1'b0; udp_rx_dstport = 16'h0; udp_rx_srcport = 16'h0;
    udp_rx_data = 8'h00; udp_rx_dven = 1'b0; udp_rx_error = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    wait_cycles(1);

    // reset state and constant fields
    check("rst_txcnt", txcnt, 64'd0);
    check("rst_request", 64'(udp_request), 64'd0);
    check("rst_dven", 64'(udp_tx_dven), 64'd0);
    check("rst_timeouts", 64'(timeouts), 64'd0);
    check("tx_length", 64'(udp_tx_length), 64'd16);
    check("tx_srcport", 64'(udp_tx_srcport), 64'hd003);
    check("tx_dstport", 64'(udp_tx_dstport), 64'hd002);
    check("tx_checksum", 64'(udp_tx_checksum), 64'd0);
    check("tx_error", 64'(udp_tx_error), 64'd0);

    // two packets, period 10
    enable = 1'b1;
    for (i = 0; i < 600 && exp_txcnt < 2; i++) @(posedge clk);
    #1;
    enable = 1'b0;
    check("wait_two_packets", 64'(exp_txcnt >= 2), 64'd1);
    check("lit_txcnt2", txcnt, 64'd2);
    if (pkt_log.size() >= 2) begin
      check("lit_pkt0", pkt_log[0], 64'h0);
      check("lit_pkt1", pkt_log[1], 64'h1);
    end else check("lit_pkt_count", 64'(pkt_log.size()), 64'd2);
    check("lit_gap", 64'(last_gap), 64'd12);
    wait_cycles(150);
    check("lit_timeout_once", 64'(timeouts), 64'd1);

    // replies 0,1 with remote byte 05
    send_reply(16'hd003, 16'hd002, 8, {8'h05, 56'd0}, -1);
    send_reply(16'hd003, 16'hd002, 8, {8'h05, 56'd1}, -1);
    check("lit_rxcnt2", rxcnt, 64'd2);
    check("lit_seqerr0", 64'(seqerr), 64'd0);
    check("lit_remote05", 64'(remote_err), 64'h05);
    // discontinuity 1 -> 3
    send_reply(16'hd003, 16'hd002, 8, {8'h00, 56'd3}, -1);
    send_reply(16'hd003, 16'hd002, 8, {8'h00, 56'd4}, -1);
    check("lit_seqerr1", 64'(seqerr), 64'd1);
    check("lit_rxcnt4", rxcnt, 64'd4);
    send_reply(16'hd003, 16'hd002, 8, {8'h00, 56'd5}, -1);
    check("lit_seqerr_still1", 64'(seqerr), 64'd1);
    check("lit_rxcnt5", rxcnt, 64'd5);
    // short reply, then errored reply
    send_reply(16'hd003, 16'hd002, 6, {8'h00, 56'd6}, -1);
    send_reply(16'hd003, 16'hd002, 8, {8'h00, 56'd6}, 3);
    check("lit_lenerr1", 64'(lenerr), 64'd1);
    check("lit_rxerr1", 64'(rxerr), 64'd1);
    check("lit_rxcnt_hold", rxcnt, 64'd5);
    // wrong ports are ignored
    send_reply(16'hd003, 16'hd001, 8, {8'h77, 56'd6}, -1);
    send_reply(16'hd004, 16'hd002, 8, {8'h77, 56'd6}, -1);
    check("lit_wrongport_rxcnt", rxcnt, 64'd5);
    check("lit_wrongport_remote", 64'(remote_err), 64'h00);
    send_reply(16'hd003, 16'hd002, 8, {8'h09, 56'd6}, -1);
    check("lit_rxcnt6", rxcnt, 64'd6);
    check("lit_seqerr_final", 64'(seqerr), 64'd1);

    // timeouts, one per packet with period 200
    period = 32'd200;
    base = 2;
    enable = 1'b1;
    for (i = 0; i < 2000 && exp_txcnt < 64'(base + 3); i++) @(posedge clk);
    #1;
    enable = 1'b0;
    check("wait_three_packets", 64'(exp_txcnt >= 64'(base + 3)), 64'd1);
    wait_cycles(150);
    check("lit_timeouts4", 64'(timeouts), 64'd4);

    // reset in the middle of DATA
    period = 32'd5;
    enable = 1'b1;
    for (i = 0; i < 300 && !udp_tx_dven; i++) begin
      @(posedge clk); #1;
    end
    check("wait_dven", 64'(udp_tx_dven), 64'd1);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rstmid_dven", 64'(udp_tx_dven), 64'd0);
    check("rstmid_data", 64'(udp_tx_data), 64'd0);
    check("rstmid_txcnt", txcnt, 64'd0);
    check("rstmid_rxcnt", rxcnt, 64'd0);
    base = pkt_log.size();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    for (i = 0; i < 300 && exp_txcnt < 1; i++) @(posedge clk);
    #1;
    enable = 1'b0;
    check("wait_post_reset_packet", 64'(exp_txcnt >= 1), 64'd1);
    if (pkt_log.size() > base) check("lit_post_reset_seq0", pkt_log[base], 64'h0);
    else check("lit_post_reset_count", 64'(pkt_log.size()), 64'(base + 1));
    check("lit_post_reset_txcnt", txcnt, 64'd1);
    wait_cycles(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
